// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 raster timing, frame buffer read addressing and
// two-entry palette lookup, clocked from the 100 MHz system clock with a
// divide-by-four pixel strobe.
module vga_scan_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CONFIG_COLOURS,
  output logic        DPR_CLK,
  output logic [14:0] VGA_ADDR,
  input  logic        VGA_DATA,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_COLOUR
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic [1:0]  r_div;
  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic [14:0] r_addr;
  logic        r_de;
  logic        r_hs;
  logic        r_vs;
  logic        r_hs_d;
  logic        r_vs_d;
  logic [7:0]  r_colour;

  logic        w_tick;
  logic [9:0]  w_hc_next;
  logic [9:0]  w_vc_next;
  logic        w_de;
  logic        w_hs;
  logic        w_vs;
  logic [14:0] w_addr_next;
  logic [7:0]  w_colour_next;

  assign w_tick = (r_div == 2'd3);

  // Free-running divide-by-four; its MSB doubles as the frame buffer clock.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div <= 2'd0;
    end else begin
      r_div <= r_div + 2'd1;
    end
  end

  // Next raster position: hc steps each pixel tick, vc steps when hc wraps.
  always_comb begin
    w_hc_next = r_hc;
    w_vc_next = r_vc;
    if (w_tick) begin
      if (r_hc == H_LAST) begin
        w_hc_next = 10'd0;
        if (r_vc == V_LAST) begin
          w_vc_next = 10'd0;
        end else begin
          w_vc_next = r_vc + 10'd1;
        end
      end else begin
        w_hc_next = r_hc + 10'd1;
        w_vc_next = r_vc;
      end
    end else begin
      w_hc_next = r_hc;
      w_vc_next = r_vc;
    end
  end

  // Raster counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hc <= 10'd0;
      r_vc <= 10'd0;
    end else begin
      r_hc <= w_hc_next;
      r_vc <= w_vc_next;
    end
  end

  // Region decode of the current raster position; address frozen in blanking.
  always_comb begin
    w_de        = (r_hc < H_VIS) && (r_vc < V_VIS);
    w_hs        = ~in_window(r_hc, HS_FIRST, HS_LAST);
    w_vs        = ~in_window(r_vc, VS_FIRST, VS_LAST);
    w_addr_next = r_addr;
    if (w_de) begin
      w_addr_next = {r_vc[8:2], r_hc[9:2]};
    end else begin
      w_addr_next = r_addr;
    end
  end

  // Fetch stage: issue the read address and carry de/sync alongside it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr <= 15'd0;
      r_de   <= 1'b0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
    end else if (w_tick) begin
      r_addr <= w_addr_next;
      r_de   <= w_de;
      r_hs   <= w_hs;
      r_vs   <= w_vs;
    end
  end

  // Palette lookup on the returned pixel; black whenever the fetch was blank.
  always_comb begin
    w_colour_next = 8'h00;
    if (r_de) begin
      if (VGA_DATA) begin
        w_colour_next = CONFIG_COLOURS[15:8];
      end else begin
        w_colour_next = CONFIG_COLOURS[7:0];
      end
    end else begin
      w_colour_next = 8'h00;
    end
  end

  // Output stage: sync delayed so it stays aligned with the looked-up colour.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hs_d   <= 1'b1;
      r_vs_d   <= 1'b1;
      r_colour <= 8'h00;
    end else if (w_tick) begin
      r_hs_d   <= r_hs;
      r_vs_d   <= r_vs;
      r_colour <= w_colour_next;
    end
  end

  assign DPR_CLK    = r_div[1];
  assign VGA_ADDR   = r_addr;
  assign VGA_HS     = r_hs_d;
  assign VGA_VS     = r_vs_d;
  assign VGA_COLOUR = r_colour;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a reduced-geometry instance checked pixel by pixel
// against a scoreboard, plus a full 640x480 instance for absolute sync timing.
module tb_vga_scan_gen;

  localparam int HD  = 32;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VD  = 16;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HD + HFP + HSW + HBP;
  localparam int VT  = VD + VFP + VSW + VBP;

  typedef struct {
    logic        hs;
    logic        vs;
    logic [7:0]  col;
    logic [14:0] addr;
  } item_t;

  logic        CLK;
  logic        RESET;
  logic [15:0] cfg;
  logic        dpr_clk;
  logic [14:0] vga_addr;
  logic        vga_data;
  logic        vga_hs;
  logic        vga_vs;
  logic [7:0]  vga_colour;

  logic        dpr_clk_b;
  logic [14:0] vga_addr_b;
  logic        big_data;
  logic        vga_hs_b;
  logic        vga_vs_b;
  logic [7:0]  vga_colour_b;

  logic        mem [32768];
  item_t       sb_q [$];
  time         hs_fall_q [$];
  time         hs_rise_q [$];
  time         vs_fall_q [$];
  time         vs_rise_q [$];
  time         t_R;
  time         big_fall_t;
  bit          big_armed;
  bit          chk_en;
  int          n_checks;
  int          n_fail;
  int          n_pushed;
  int          n_popped;
  logic [14:0] m_addr;
  logic [15:0] m_pal;

  vga_scan_gen #(
    .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CONFIG_COLOURS(cfg), .DPR_CLK(dpr_clk),
    .VGA_ADDR(vga_addr), .VGA_DATA(vga_data), .VGA_HS(vga_hs),
    .VGA_VS(vga_vs), .VGA_COLOUR(vga_colour)
  );

  vga_scan_gen dut_full (
    .CLK(CLK), .RESET(RESET), .CONFIG_COLOURS(cfg), .DPR_CLK(dpr_clk_b),
    .VGA_ADDR(vga_addr_b), .VGA_DATA(big_data), .VGA_HS(vga_hs_b),
    .VGA_VS(vga_vs_b), .VGA_COLOUR(vga_colour_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Frame buffer model: one DPR_CLK of read latency.
  always @(posedge dpr_clk) vga_data <= mem[vga_addr];

  // Edge recorders for sync timing.
  always @(negedge vga_hs) hs_fall_q.push_back($time);
  always @(posedge vga_hs) hs_rise_q.push_back($time);
  always @(negedge vga_vs) vs_fall_q.push_back($time);
  always @(posedge vga_vs) vs_rise_q.push_back($time);
  always @(negedge vga_hs_b) begin
    if (big_armed) begin
      big_fall_t = $time;
      big_armed  = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raster rules evaluated from a pixel index.
  function automatic int px(input int p); return p % HT; endfunction
  function automatic int py(input int p); return (p / HT) % VT; endfunction
  function automatic bit m_de(input int p); return (px(p) < HD) && (py(p) < VD); endfunction
  function automatic logic m_hs(input int p);
    return !((px(p) >= HD + HFP) && (px(p) < HD + HFP + HSW));
  endfunction
  function automatic logic m_vs(input int p);
    return !((py(p) >= VD + VFP) && (py(p) < VD + VFP + VSW));
  endfunction
  function automatic logic [14:0] m_fb_addr(input int p);
    return 15'(((py(p) / 4) * 256) + (px(p) / 4));
  endfunction

  // Scoreboard monitor: the falling edge of DPR_CLK marks each pixel tick.
  always begin
    item_t it;
    @(negedge dpr_clk);
    #1;
    if (chk_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        it = sb_q.pop_front();
        n_popped++;
        chk("hs",     32'(vga_hs),     32'(it.hs));
        chk("vs",     32'(vga_vs),     32'(it.vs));
        chk("colour", 32'(vga_colour), 32'(it.col));
        chk("addr",   32'(vga_addr),   32'(it.addr));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hs"},     32'(vga_hs),       32'd1);
    chk({tag, "_vs"},     32'(vga_vs),       32'd1);
    chk({tag, "_colour"}, 32'(vga_colour),   32'd0);
    chk({tag, "_addr"},   32'(vga_addr),     32'd0);
    chk({tag, "_dprclk"}, 32'(dpr_clk),      32'd0);
    chk({tag, "_hs_b"},   32'(vga_hs_b),     32'd1);
    chk({tag, "_vs_b"},   32'(vga_vs_b),     32'd1);
    chk({tag, "_col_b"},  32'(vga_colour_b), 32'd0);
  endtask

  // Called at a negedge with RESET just dropped: the next posedge is edge R.
  task automatic do_release();
    RESET = 1'b0;
    t_R   = $time + 5;
    m_addr = 15'd0;
    hs_fall_q.delete(); hs_rise_q.delete();
    vs_fall_q.delete(); vs_rise_q.delete();
    big_fall_t = 0;
    big_armed  = 1'b1;
    chk_en     = 1'b1;
  endtask

  // Driver: one iteration per pixel tick k, starting at a negedge.
  task automatic run_pixels(input int k_first, input int k_last, input bit rnd, input int pal_k);
    item_t it;
    for (int k = k_first; k <= k_last; k++) begin
      if (k == pal_k) m_pal = 16'h1C03;
      else if (rnd && ($urandom_range(0, 15) == 0)) m_pal = 16'($urandom);
      cfg = m_pal;
      if (k == 0) begin
        it.hs = 1'b1; it.vs = 1'b1; it.col = 8'h00;
      end else begin
        it.hs = m_hs(k - 1);
        it.vs = m_vs(k - 1);
        if (m_de(k - 1)) it.col = mem[m_addr] ? m_pal[15:8] : m_pal[7:0];
        else             it.col = 8'h00;
      end
      if (m_de(k)) m_addr = m_fb_addr(k);
      it.addr = m_addr;
      sb_q.push_back(it);
      n_pushed++;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      if (px(k) == 4 && py(k) == 0)           chk("addr_4_0",    32'(vga_addr), 32'h0001);
      if (px(k) < 4 && py(k) < 4)             chk("addr_blk0",   32'(vga_addr), 32'h0000);
      if (px(k) == HD - 1 && py(k) == VD - 1) chk("addr_last",   32'(vga_addr), 32'h0307);
    end
  endtask

  task automatic check_first_edges(input string tag);
    chk({tag, "_hs_seen"}, 32'(hs_fall_q.size() > 0), 32'd1);
    chk({tag, "_vs_seen"}, 32'(vs_fall_q.size() > 0), 32'd1);
    if (hs_fall_q.size() > 0)
      chk({tag, "_hs_first"}, 32'((hs_fall_q[0] - t_R) / 10), 32'((HD + HFP + 1) * 4 + 3));
    if (vs_fall_q.size() > 0)
      chk({tag, "_vs_first"}, 32'((vs_fall_q[0] - t_R) / 10), 32'(4 * ((VD + VFP) * HT + 1) + 3));
    chk({tag, "_full_hs_first"}, 32'((big_fall_t - t_R) / 10), 32'((656 + 1) * 4 + 3));
  endtask

  task automatic check_sync_periods();
    chk("hs_fall_count", 32'(hs_fall_q.size() >= 70), 32'd1);
    chk("vs_fall_count", 32'(vs_fall_q.size() >= 3), 32'd1);
    for (int i = 1; i < hs_fall_q.size(); i++)
      chk("hs_period", 32'((hs_fall_q[i] - hs_fall_q[i-1]) / 10), 32'(4 * HT));
    for (int i = 0; i < hs_rise_q.size() && i < hs_fall_q.size(); i++)
      chk("hs_low", 32'((hs_rise_q[i] - hs_fall_q[i]) / 10), 32'(4 * HSW));
    for (int i = 1; i < vs_fall_q.size(); i++)
      chk("vs_period", 32'((vs_fall_q[i] - vs_fall_q[i-1]) / 10), 32'(4 * HT * VT));
    for (int i = 0; i < vs_rise_q.size() && i < vs_fall_q.size(); i++)
      chk("vs_low", 32'((vs_rise_q[i] - vs_fall_q[i]) / 10), 32'(4 * HT * VSW));
    for (int i = 0; i < vs_fall_q.size(); i++)
      chk("vs_fall_align", 32'((((vs_fall_q[i] - t_R) / 10) - 7) % (4 * HT)), 32'd0);
    for (int i = 0; i < vs_rise_q.size(); i++)
      chk("vs_rise_align", 32'((((vs_rise_q[i] - t_R) / 10) - 7) % (4 * HT)), 32'd0);
  endtask

  localparam int NA     = VT * HT + 100;
  localparam int K_MID  = 3 * VT * HT + 10 * HT + 20 - 1;
  localparam int NC     = (VD + VFP) * HT + 10;

  initial begin
    n_checks = 0; n_fail = 0; n_pushed = 0; n_popped = 0;
    chk_en = 1'b0; big_armed = 1'b0; big_fall_t = 0; t_R = 0;
    big_data = 1'b0;
    RESET = 1'b1;
    m_pal = 16'hFF00;
    cfg   = m_pal;
    m_addr = 15'd0;
    for (int i = 0; i < 32768; i++) mem[i] = (((i & 1) ^ ((i >> 8) & 1)) != 0);

    // Power-on reset held for five clocks.
    repeat (5) @(negedge CLK);
    check_reset_vals("por");

    // Checkerboard with FF/00 palette, palette switched mid-line on line 3.
    do_release();
    run_pixels(0, NA - 1, 1'b0, 3 * HT + 10);
    check_first_edges("por");

    // Random frame buffer and random palette changes over further frames.
    for (int i = 0; i < 32768; i++) mem[i] = ($urandom_range(0, 1) == 1);
    run_pixels(NA, K_MID, 1'b1, -1);
    check_sync_periods();
    chk("sb_drain_b", 32'(sb_q.size()), 32'd0);

    // One-clock reset in the middle of a visible line.
    chk_en = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_vals("mid");
    do_release();
    run_pixels(0, NC, 1'b1, -1);
    check_first_edges("mid");

    chk("sb_count", 32'(n_popped), 32'(n_pushed));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
